// File: rtl/sram_ctrl_if.sv
// Client-side request/response bundle for sram_ctrl.
// master = requesting client, slave = controller.
interface sram_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    logic              mem;
    logic              rw;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data2ram;
    logic [DATA_W-1:0] data2fpga;

    modport master (
        output mem, rw, addr, data2ram,
        input  ready, data2fpga
    );

    modport slave (
        input  mem, rw, addr, data2ram,
        output ready, data2fpga
    );
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: single-word read/write over mem/rw/ready,
// with parameterised strobe widths. All pin-side outputs are registered.
// Optional macro SRAM_CTRL_TURNAROUND_EN adds a one-cycle bus turnaround
// state after every read.
//
// state   | meaning
// S_IDLE  | ready, strobes deasserted, waiting for mem
// S_WRITE | ce_n/we_n low, FPGA drives dq (WR_CYCLES cycles)
// S_WHOLD | we_n released, dq still driven for data hold (1 cycle)
// S_READ  | ce_n/oe_n low, dq captured on last cycle (RD_CYCLES cycles)
// S_TURN  | all strobes released before next access (1 cycle, optional)
module sram_ctrl #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 8,
    parameter int WR_CYCLES = 3,
    parameter int RD_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WHOLD = 3'd2,
        S_READ  = 3'd3,
        S_TURN  = 3'd4
    } state_t;

    localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);
    localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);

    state_t     state, next_state;
    logic [3:0] cnt;
    logic       accept;
    logic       rd_done;
    logic       ce_n_d, oe_n_d, we_n_d, dq_oe_d;

    assign bus.ready = (state == S_IDLE);
    assign accept    = bus.mem && (state == S_IDLE);
    assign rd_done   = (state == S_READ) && (cnt == RD_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state decode; unknown encodings fall back to idle.
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:  next_state = accept ? (bus.rw ? S_READ : S_WRITE) : S_IDLE;
            S_WRITE: next_state = (cnt == WR_LAST) ? S_WHOLD : S_WRITE;
            S_WHOLD: next_state = S_IDLE;
`ifdef SRAM_CTRL_TURNAROUND_EN
            S_READ:  next_state = rd_done ? S_TURN : S_READ;
            S_TURN:  next_state = S_IDLE;
`else
            S_READ:  next_state = rd_done ? S_IDLE : S_READ;
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // Strobe values for the state being entered, so the pin flops line up with it.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (next_state)
            S_WRITE: begin ce_n_d = 1'b0; we_n_d = 1'b0; dq_oe_d = 1'b1; end
            S_WHOLD: begin ce_n_d = 1'b0; dq_oe_d = 1'b1; end
            S_READ:  begin ce_n_d = 1'b0; oe_n_d = 1'b0; end
            default: ;
        endcase
    end

    // Wait-state counter: 0..N-1 within a strobe phase, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else begin
            case (state)
                S_WRITE: cnt <= (cnt == WR_LAST) ? 4'd0 : cnt + 4'd1;
                S_READ:  cnt <= rd_done ? 4'd0 : cnt + 4'd1;
                default: cnt <= 4'd0;
            endcase
        end
    end

    // Pin and data registers; address/write data latched only at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_dq_oe    <= 1'b0;
            sram_addr     <= '0;
            sram_dq_o     <= '0;
            bus.data2fpga <= '0;
        end else begin
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            sram_dq_oe <= dq_oe_d;
            if (accept) begin
                sram_addr <= bus.addr;
                if (!bus.rw) sram_dq_o <= bus.data2ram;
            end
            if (rd_done) bus.data2fpga <= sram_dq_i;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural SRAM and a read-data scoreboard.
module tb_sram_ctrl;
    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 8;
    localparam int WR_CYCLES = 3;
    localparam int RD_CYCLES = 3;
`ifdef SRAM_CTRL_TURNAROUND_EN
    localparam int TURN_CYC  = 1;
`else
    localparam int TURN_CYC  = 0;
`endif
    localparam int TIMEOUT   = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_o;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_i;
    logic              sram_ce_n, sram_oe_n, sram_we_n;

    sram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .WR_CYCLES(WR_CYCLES), .RD_CYCLES(RD_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #10 clk = ~clk;

    // Behavioural SRAM, 4K deep (low address bits).
    logic [7:0] sram_mem [0:4095];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[11:0]] : 8'hEE;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe)
            sram_mem[sram_addr[11:0]] <= sram_dq_o;
    end

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] ref_mem [0:4095];
    logic [7:0] exp_q [$];
    logic [7:0] last_rd = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) check("dq_oe_oe_overlap", {31'd0, sram_dq_oe & ~sram_oe_n}, 32'd0);

    // One request issued at a negedge with ready=1; returns at the first ready=1 negedge.
    task automatic xfer(input logic is_rd, input logic [19:0] a, input logic [7:0] d);
        int lo, we_lo, oe_lo, hold, turn, bad_dq, bad_rd, bad_addr, t;
        logic [7:0] e;
        lo = 0; we_lo = 0; oe_lo = 0; hold = 0; turn = 0;
        bad_dq = 0; bad_rd = 0; bad_addr = 0; t = 0;
        check("ready_before_req", {31'd0, bus.ready}, 32'd1);
        bus.mem = 1'b1; bus.rw = is_rd; bus.addr = a; bus.data2ram = d;
        if (is_rd) exp_q.push_back(ref_mem[a[11:0]]);
        else       ref_mem[a[11:0]] = d;
        @(negedge clk);
        bus.mem = 1'b0; bus.rw = 1'($urandom);
        bus.addr = 20'($urandom); bus.data2ram = 8'($urandom);
        while (bus.ready !== 1'b1 && t < TIMEOUT) begin
            lo++;
            if (sram_addr !== a) bad_addr++;
            if (!sram_we_n) begin
                we_lo++;
                if (!sram_dq_oe || sram_dq_o !== d || sram_ce_n) bad_dq++;
            end
            if (!sram_oe_n) begin
                oe_lo++;
                if (sram_dq_oe || sram_ce_n) bad_rd++;
            end
            if (!sram_ce_n && sram_we_n && sram_dq_oe) hold++;
            if (sram_ce_n && !sram_dq_oe && sram_oe_n && sram_we_n) turn++;
            @(negedge clk);
            t++;
        end
        check("ready_timeout", {31'd0, (t >= TIMEOUT)}, 32'd0);
        check("sram_addr_held", 32'(bad_addr), 32'd0);
        if (is_rd) begin
            check("rd_ready_low", 32'(lo), 32'(RD_CYCLES + TURN_CYC));
            check("rd_oe_low", 32'(oe_lo), 32'(RD_CYCLES));
            check("rd_strobe_bad", 32'(bad_rd), 32'd0);
            check("rd_we_low", 32'(we_lo), 32'd0);
            check("rd_turn_cycles", 32'(turn), 32'(TURN_CYC));
            check("rd_queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_data2fpga", {24'd0, bus.data2fpga}, {24'd0, e});
                last_rd = e;
            end
        end else begin
            check("wr_ready_low", 32'(lo), 32'(WR_CYCLES + 1));
            check("wr_we_low", 32'(we_lo), 32'(WR_CYCLES));
            check("wr_dq_bad", 32'(bad_dq), 32'd0);
            check("wr_hold_cycles", 32'(hold), 32'd1);
            check("wr_oe_low", 32'(oe_lo), 32'd0);
            check("wr_data2fpga_kept", {24'd0, bus.data2fpga}, {24'd0, last_rd});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            sram_mem[i] = 8'h00;
            ref_mem[i]  = 8'h00;
        end
        bus.mem = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.data2ram = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset held with mem asserted: no strobe activity.
        bus.mem = 1'b1; bus.rw = 1'b1; bus.addr = 20'h00abc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
            check("rst_ready", {31'd0, bus.ready}, 32'd1);
        end
        check("rst_data2fpga", {24'd0, bus.data2fpga}, 32'd0);
        check("rst_sram_addr", {12'd0, sram_addr}, 32'd0);
        check("rst_sram_dq_o", {24'd0, sram_dq_o}, 32'd0);
        bus.mem = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {27'd0, bus.ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'h1E);

        // Single write, read back, then a write that must not disturb data2fpga.
        xfer(1'b0, 20'h00000, 8'h01);
        xfer(1'b1, 20'h00000, 8'h00);
        xfer(1'b0, 20'h00000, 8'h80);
        check("data2fpga_after_write", {24'd0, bus.data2fpga}, 32'h01);

        // Walking ones, back-to-back.
        for (int b = 0; b < 8; b++) begin
            xfer(1'b0, 20'h00000, 8'(1 << b));
            xfer(1'b1, 20'h00000, 8'h00);
        end

        // Reset during the second write cycle aborts the access.
        xfer(1'b0, 20'h12345, 8'h5A);
        bus.mem = 1'b1; bus.rw = 1'b0; bus.addr = 20'h00100; bus.data2ram = 8'hA5;
        @(negedge clk);
        bus.mem = 1'b0;
        check("abort_wr_cycle1", {31'd0, sram_we_n}, 32'd0);
        @(negedge clk);
        check("abort_wr_cycle2", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        check("abort_data2fpga", {24'd0, bus.data2fpga}, 32'd0);
        last_rd = 8'h00;
        xfer(1'b1, 20'h12345, 8'h00);

        // Read immediately followed by a write, then read that back.
        xfer(1'b1, 20'h00000, 8'h00);
        xfer(1'b0, 20'h00001, 8'h3C);
        xfer(1'b1, 20'h00001, 8'h00);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
